// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the external 32-bit combinational ALU.
// Accepts one instruction, reads operands from a 16x32 register file, executes and writes back.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        in_use_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    output logic        done,
    output logic        err,
    output logic [31:0] out_result,
    output logic [3:0]  out_rd,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int unsigned NREG      = 16;
    localparam logic [3:0]  OpLui     = 4'd14;
    localparam logic [3:0]  OpIllegal = 4'd15;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        use_imm_q, use_imm_d;
    logic [31:0] result_q, result_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rf_q [NREG];
    logic [31:0] rf_d [NREG];

    logic [3:0]  op, rd, rs, rt;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, imm_ext;

    assign op  = instr_q[31:28];
    assign rd  = instr_q[27:24];
    assign rs  = instr_q[23:20];
    assign rt  = instr_q[19:16];
    assign imm = instr_q[15:0];

    assign rs_val  = (rs == 4'd0) ? 32'd0 : rf_q[rs];
    assign rt_val  = (rt == 4'd0) ? 32'd0 : rf_q[rt];
    // lui places the immediate in the upper half, so it must not be sign-extended
    assign imm_ext = (op == OpLui) ? {16'd0, imm} : {{16{imm[15]}}, imm};

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        use_imm_d = use_imm_q;
        result_d  = result_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rf_d      = rf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    instr_d   = in_instr;
                    use_imm_d = in_use_imm;
                    // err is registered so the pulse lands in the READ cycle
                    err_d     = (in_instr[31:28] == OpIllegal);
                    state_d   = StRead;
                end
            end
            StRead: begin
                if (op == OpIllegal) begin
                    state_d = StIdle;
                end else begin
                    alu_a_d  = rs_val;
                    alu_b_d  = use_imm_q ? imm_ext : rt_val;
                    alu_op_d = op;
                    state_d  = StExec;
                end
            end
            StExec: begin
                result_d = alu_result;
                done_d   = 1'b1;
                state_d  = StWb;
            end
            StWb: begin
                if (rd != 4'd0) begin
                    rf_d[rd] = result_q;
                end
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            use_imm_q <= 1'b0;
            result_q  <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            use_imm_q <= use_imm_d;
            result_q  <= result_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rf_q      <= rf_d;
        end
    end

    assign in_ready   = (state_q == StIdle) && !rst;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign done       = done_q;
    assign err        = err_q;
    assign out_result = result_q;
    assign out_rd     = rd;
    assign dbg_data   = (dbg_addr == 4'd0) ? 32'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl with a behavioural ALU and register-file model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        in_use_imm = 1'b0;
    logic [31:0] alu_a, alu_b, alu_result, out_result, dbg_data;
    logic [3:0]  alu_opcode, out_rd;
    logic [3:0]  dbg_addr = '0;
    logic        done, err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_use_imm (in_use_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .done       (done),
        .err        (err),
        .out_result (out_result),
        .out_rd     (out_rd),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return ~a;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return 32'($signed(a) >>> b[4:0]);
            4'd10:   return a + 32'd1;
            4'd11:   return a - 32'd1;
            4'd12:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13:   return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            4'd14:   return b << 16;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    typedef struct {
        bit          is_err;
        logic [3:0]  rd;
        logic [3:0]  op;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [16];
    int          last_acc = -1;
    bit          last_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done/err and tracks committed register contents.
    initial begin
        logic [31:0] commit [16];
        bit          pend = 1'b0;
        logic [3:0]  pend_rd = '0;
        logic [31:0] pend_val = '0;
        exp_t        e;
        for (int i = 0; i < 16; i++) commit[i] = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 16; i++) commit[i] = '0;
                pend = 1'b0;
            end else if (pend) begin
                if (pend_rd != 4'd0) commit[pend_rd] = pend_val;
                pend = 1'b0;
            end
            @(negedge clk);
            dbg_addr = 4'($urandom_range(0, 15));
            #1;
            chk("dbg_data", dbg_data, commit[dbg_addr]);
            chk("done_err_exclusive", {31'd0, done & err}, 32'd0);
            if (done || err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_err) begin
                        chk("err_pulse", {31'd0, err}, 32'd1);
                        chk("err_latency", 32'(cyc - e.acc), 32'd1);
                    end else begin
                        chk("done_pulse", {31'd0, done}, 32'd1);
                        chk("done_latency", 32'(cyc - e.acc), 32'd3);
                        chk("out_result", out_result, e.res);
                        chk("out_rd", {28'd0, out_rd}, {28'd0, e.rd});
                        chk("alu_a", alu_a, e.a);
                        chk("alu_b", alu_b, e.b);
                        chk("alu_opcode", {28'd0, alu_opcode}, {28'd0, e.op});
                        pend     = 1'b1;
                        pend_rd  = e.rd;
                        pend_val = e.res;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        sbq.delete();
        for (int i = 0; i < 16; i++) model[i] = '0;
        last_acc = -1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {28'd0, out_rd}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    endtask

    // Offers one instruction, waits (bounded) for acceptance, predicts its outcome.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [15:0] imm, input logic ui);
        int          n = 0;
        bit          held;
        exp_t        e;
        logic [31:0] a, b;
        held       = in_valid;
        in_valid   = 1'b1;
        in_instr   = {op, rd, rs, rt, imm};
        in_use_imm = ui;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (held && last_acc >= 0) begin
            chk("accept_gap", 32'(cyc - last_acc), last_ill ? 32'd2 : 32'd4);
        end
        a = (rs == 4'd0) ? 32'd0 : model[rs];
        if (ui) b = (op == 4'd14) ? {16'd0, imm} : {{16{imm[15]}}, imm};
        else    b = (rt == 4'd0) ? 32'd0 : model[rt];
        e.is_err = (op == 4'd15);
        e.rd     = rd;
        e.op     = op;
        e.a      = a;
        e.b      = b;
        e.res    = alu_fn(op, a, b);
        e.acc    = cyc;
        sbq.push_back(e);
        if (!e.is_err && rd != 4'd0) model[rd] = e.res;
        last_acc = cyc;
        last_ill = e.is_err;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        do_reset();
        // Seed R1=5, R2=7 then add them
        issue(4'd0, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1);
        idle(1);
        issue(4'd0, 4'd2, 4'd0, 4'd0, 16'd7, 1'b1);
        idle(2);
        issue(4'd0, 4'd3, 4'd1, 4'd2, 16'd0, 1'b0);
        idle(1);
        issue(4'd1, 4'd4, 4'd0, 4'd0, 16'h0001, 1'b1);
        idle(1);
        issue(4'd14, 4'd5, 4'd0, 4'd0, 16'h8001, 1'b1);
        idle(1);
        // Illegal op then a held write to R0
        issue(4'd15, 4'd6, 4'd1, 4'd2, 16'd0, 1'b0);
        issue(4'd0, 4'd0, 4'd1, 4'd2, 16'd0, 1'b0);
        idle(1);
        // Back-to-back: second reads the first's writeback
        issue(4'd0, 4'd7, 4'd3, 4'd0, 16'd1, 1'b1);
        issue(4'd4, 4'd8, 4'd7, 4'd3, 16'd0, 1'b0);
        idle(3);
        // Reset while the instruction is in EXEC
        issue(4'd0, 4'd9, 4'd3, 4'd3, 16'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        do_reset();
        idle(6);
        for (int i = 0; i < 200; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  16'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 1'b0;
        w = 0;
        while (sbq.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
